i2c_slave_responder: RTL and testbench

- I2C target (slave) responder: the device-side end of the I2C master already used for the ADC register reads.
- Answers a 7-bit device address and exposes an 8-bit register space through a simple synchronous register-bus port.
- Used both as an on-board stand-in target for master bring-up and as the FPGA's own I2C register port to the MCU.
- Supports standard/fast mode, byte writes/reads with pointer auto-increment, repeated START, no clock stretching.

---
 rtl/i2c_slave_responder.sv | 152 +++++++++++++++
 tb/tb_i2c_slave_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// I2C target responder: answers DEVICE_ID and maps byte reads/writes onto a
// simple register bus with an auto-incrementing pointer. No clock stretching.
module i2c_slave_responder #(
  parameter logic [6:0] DEVICE_ID  = 7'h54,
  parameter int         FILTER_LEN = 3,
  parameter int         HOLD_CYC   = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);

  typedef enum logic [2:0] {IDLE, ADDR, REG, WDATA, RDATA, WAIT_STOP} state_t;
  state_t state, state_n;

  logic          scl_p0, scl_p1, sda_p0, sda_p1;
  logic          scl_f, sda_f, scl_q, sda_q;
  logic [FW-1:0] scl_cnt, sda_cnt;
  logic [HW-1:0] hold_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    rx_sh, tx_sh, rx_byte;
  logic          rd_req_p1, oe_target;
  logic          scl_rise, scl_fall, start_det, stop_det, ev_ok;
  logic          rise8, rise9, fall9, hold_done, addr_ok, in_byte;

  // Stage p0/p1: synchroniser, then glitch filter and edge history
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; sda_p0 <= 1'b1; sda_p1 <= 1'b1;
      scl_f  <= 1'b1; sda_f  <= 1'b1; scl_q  <= 1'b1; sda_q  <= 1'b1;
      scl_cnt <= '0;  sda_cnt <= '0;
    end else begin
      scl_p0 <= scl_in; scl_p1 <= scl_p0;
      sda_p0 <= sda_in; sda_p1 <= sda_p0;
      if (scl_p1 == scl_f) scl_cnt <= '0;
      else if (scl_cnt == FW'(FILTER_LEN - 1)) begin
        scl_f   <= scl_p1;
        scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + 1'b1;
      if (sda_p1 == sda_f) sda_cnt <= '0;
      else if (sda_cnt == FW'(FILTER_LEN - 1)) begin
        sda_f   <= sda_p1;
        sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + 1'b1;
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // Bus events; START/STOP preempt any bit-level event in the same cycle
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign ev_ok     = ~start_det & ~stop_det;
  assign rise8     = ev_ok & scl_rise & (bit_cnt == 4'd7);
  assign rise9     = ev_ok & scl_rise & (bit_cnt == 4'd8);
  assign fall9     = ev_ok & scl_fall & (bit_cnt == 4'd9);
  assign hold_done = (hold_cnt == HW'(1));
  assign rx_byte   = {rx_sh[6:0], sda_f};
  assign addr_ok   = (rx_byte[7:1] == DEVICE_ID);
  assign in_byte   = (state == ADDR) || (state == REG) || (state == WDATA) || (state == RDATA);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    oe_target = 1'b0;
    case (state)
      ADDR: begin
        oe_target = (bit_cnt == 4'd8);
        if (rise8 && !addr_ok) state_n = WAIT_STOP;
        else if (fall9)        state_n = rx_sh[0] ? RDATA : REG;
      end
      REG: begin
        oe_target = (bit_cnt == 4'd8);
        if (fall9) state_n = WDATA;
      end
      WDATA: oe_target = (bit_cnt == 4'd8);
      RDATA: begin
        // Bit 9 belongs to the master, so SDA is released for it
        oe_target = (bit_cnt < 4'd8) & ~tx_sh[7];
        if (rise9 && sda_f) state_n = WAIT_STOP;
      end
      default: ;
    endcase
    if (start_det)     state_n = ADDR;
    else if (stop_det) state_n = IDLE;
  end

  // Stage p2: bit counter, SDA drive with hold delay, register-bus strobes
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bit_cnt   <= '0;
      hold_cnt  <= '0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      rd_req    <= 1'b0;
      rd_req_p1 <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      rd_req    <= fall9 & (((state == ADDR) & rx_sh[0]) | (state == RDATA));
      rd_req_p1 <= rd_req;

      if (scl_fall)            hold_cnt <= HW'(HOLD_CYC);
      else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;

      if (!ev_ok || fall9)                           bit_cnt <= '0;
      else if (scl_rise && in_byte && bit_cnt != 4'd9) bit_cnt <= bit_cnt + 1'b1;

      if (!ev_ok)                  sda_oe <= 1'b0;
      else if (hold_done && !scl_f) sda_oe <= oe_target;

      if (stop_det)                                busy <= 1'b0;
      else if (state == ADDR && rise8 && addr_ok)  busy <= 1'b1;

      if (state == REG && rise8) reg_addr <= rx_byte;
      if (state == WDATA && rise8) begin
        wr_en   <= 1'b1;
        wr_data <= rx_byte;
      end
      if ((state == WDATA && fall9) || (state == RDATA && rise9))
        reg_addr <= reg_addr + 1'b1;
    end
  end

  // Receive and transmit shifters carry data only and need no reset
  always_ff @(posedge sys_clk) begin
    if (scl_rise && bit_cnt < 4'd8) rx_sh <= rx_byte;
    if (rd_req_p1) tx_sh <= rd_data;
    else if (scl_fall && state == RDATA && bit_cnt != 4'd0 && bit_cnt < 4'd8)
      tx_sh <= {tx_sh[6:0], 1'b0};
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged master on a wired-AND
// SDA line plus a register-bus model whose rd_data is reg_addr ^ 8'hFF.
module tb_i2c_slave_responder;

  localparam int Q = 12;  // sys_clk cycles per quarter SCL period

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, wr_en, rd_req, busy;
  logic [7:0] reg_addr, wr_data;
  logic [7:0] rd_data = 8'h00;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #5 sys_clk = ~sys_clk;

  i2c_slave_responder dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .sda_oe  (sda_oe),
    .reg_addr(reg_addr),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_req  (rd_req),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always @(posedge sys_clk) if (rd_req) rd_data <= reg_addr ^ 8'hFF;

  int         wr_n = 0, rd_n = 0, oe_n = 0;
  logic [7:0] wr_a [32];
  logic [7:0] wr_d [32];

  always @(negedge sys_clk) begin
    if (wr_en) begin
      if (wr_n < 32) begin
        wr_a[wr_n] = reg_addr;
        wr_d[wr_n] = wr_data;
      end
      wr_n++;
    end
    if (rd_req) rd_n++;
    if (sda_oe) oe_n++;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clk_bit(input logic b, input bit glitch, output logic s);
    sda_m = b;
    cyc(Q);
    scl_m = 1'b1;
    if (glitch) begin
      cyc(Q / 2);
      scl_m = 1'b0;
      cyc(1);
      scl_m = 1'b1;
      cyc(Q / 2 - 1);
    end else cyc(Q);
    s = sda_in;
    cyc(Q);
    scl_m = 1'b0;
    cyc(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b1; cyc(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], i == glitch_bit, s);
    clk_bit(1'b1, 1'b0, s);
    acked = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    clk_bit(~mack, 1'b0, s);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         w0, r0, o0;

    cyc(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_busy", busy, 0);
    sys_rst = 1'b0;
    cyc(10);

    // Pointer write then two data bytes
    w0 = wr_n;
    i2c_start();
    send_byte(8'hA8, -1, ack); chk("t1_ack_addr", ack, 1);
    chk("t1_busy", busy, 1);
    send_byte(8'h10, -1, ack); chk("t1_ack_reg", ack, 1);
    send_byte(8'hA5, -1, ack); chk("t1_ack_d0", ack, 1);
    send_byte(8'h3C, -1, ack); chk("t1_ack_d1", ack, 1);
    i2c_stop();
    cyc(10);
    chk("t1_wr_count", wr_n - w0, 2);
    chk("t1_wr0_addr", wr_a[w0], 8'h10);
    chk("t1_wr0_data", wr_d[w0], 8'hA5);
    chk("t1_wr1_addr", wr_a[w0+1], 8'h11);
    chk("t1_wr1_data", wr_d[w0+1], 8'h3C);
    chk("t1_reg_addr", reg_addr, 8'h12);
    chk("t1_busy_stop", busy, 0);

    // Pointer write, repeated START, two-byte read
    r0 = rd_n;
    i2c_start();
    send_byte(8'hA8, -1, ack); chk("t2_ack_addr", ack, 1);
    send_byte(8'h20, -1, ack); chk("t2_ack_reg", ack, 1);
    i2c_start();
    send_byte(8'hA9, -1, ack); chk("t2_ack_raddr", ack, 1);
    recv_byte(1'b1, d); chk("t2_rd0", d, 8'hDF);
    recv_byte(1'b0, d); chk("t2_rd1", d, 8'hDE);
    chk("t2_oe_after_nack", sda_oe, 0);
    chk("t2_rd_req_count", rd_n - r0, 2);
    chk("t2_reg_addr", reg_addr, 8'h22);
    i2c_stop();
    cyc(10);

    // Wrong device address
    w0 = wr_n; r0 = rd_n; o0 = oe_n;
    i2c_start();
    send_byte(8'hAA, -1, ack); chk("t3_nack_addr", ack, 0);
    send_byte(8'h5A, -1, ack); chk("t3_nack_data", ack, 0);
    chk("t3_busy", busy, 0);
    i2c_stop();
    cyc(10);
    chk("t3_oe_cycles", oe_n - o0, 0);
    chk("t3_wr_count", wr_n - w0, 0);
    chk("t3_rd_count", rd_n - r0, 0);

    // Pointer wrap from 0xFF
    w0 = wr_n;
    i2c_start();
    send_byte(8'hA8, -1, ack);
    send_byte(8'hFF, -1, ack);
    send_byte(8'h11, -1, ack); chk("t4_ack_d0", ack, 1);
    send_byte(8'h22, -1, ack); chk("t4_ack_d1", ack, 1);
    i2c_stop();
    cyc(10);
    chk("t4_wr_count", wr_n - w0, 2);
    chk("t4_wr0_addr", wr_a[w0], 8'hFF);
    chk("t4_wr0_data", wr_d[w0], 8'h11);
    chk("t4_wr1_addr", wr_a[w0+1], 8'h00);
    chk("t4_wr1_data", wr_d[w0+1], 8'h22);
    chk("t4_reg_addr", reg_addr, 8'h01);

    // One-cycle SCL glitch inside the address byte
    i2c_start();
    send_byte(8'hA8, 3, ack); chk("t5_glitch_ack", ack, 1);
    send_byte(8'h40, -1, ack); chk("t5_glitch_reg_ack", ack, 1);
    i2c_stop();
    cyc(10);
    chk("t5_glitch_reg_addr", reg_addr, 8'h40);

    // STOP after four data bits
    w0 = wr_n;
    i2c_start();
    send_byte(8'hA8, -1, ack);
    send_byte(8'h50, -1, ack);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b0, ack);
    i2c_stop();
    cyc(10);
    chk("t5_abort_wr_count", wr_n - w0, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_reg_addr", reg_addr, 8'h50);
    chk("t5_abort_oe", sda_oe, 0);

    // Reset while driving read data (0x80 ^ 0xFF = 0x7F, MSB 0 -> SDA driven low)
    i2c_start();
    send_byte(8'hA8, -1, ack);
    send_byte(8'h80, -1, ack);
    i2c_start();
    send_byte(8'hA9, -1, ack); chk("t6_ack_raddr", ack, 1);
    chk("t6_oe_before_rst", sda_oe, 1);
    sys_rst = 1'b1;
    #1;
    chk("t6_oe_in_rst", sda_oe, 0);
    chk("t6_reg_addr_rst", reg_addr, 0);
    chk("t6_busy_rst", busy, 0);
    chk("t6_wr_data_rst", wr_data, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    cyc(5);
    sys_rst = 1'b0;
    cyc(20);
    w0 = wr_n;
    i2c_start();
    send_byte(8'hA8, -1, ack); chk("t6_post_ack_addr", ack, 1);
    send_byte(8'h07, -1, ack); chk("t6_post_ack_reg", ack, 1);
    send_byte(8'h99, -1, ack); chk("t6_post_ack_data", ack, 1);
    i2c_stop();
    cyc(10);
    chk("t6_post_wr_count", wr_n - w0, 1);
    chk("t6_post_wr_addr", wr_a[w0], 8'h07);
    chk("t6_post_wr_data", wr_d[w0], 8'h99);
    chk("t6_post_reg_addr", reg_addr, 8'h08);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
